// File: rtl/psum_requant.sv
// psum_requant: accumulates K-tile psums on a bias, then rounds, ReLUs and saturates to int8
module psum_requant #(
   parameter int PW = 17,
   parameter int AW = 24,
   parameter int OW = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           i_cfg_tiles,
   input  logic [4:0]           i_cfg_shift,
   input  logic                 i_cfg_relu,
   input  logic signed [AW-1:0] i_bias,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic signed [PW-1:0] i_in_psum,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic signed [OW-1:0] o_out_data,
   output logic                 o_busy,
   output logic                 o_ovf,
   input  logic                 i_ovf_clr
);
   typedef enum logic [1:0] {IDLE, ACC, QUANT, OUT} state_t;
   state_t r_state, w_next;
   logic signed [AW-1:0] r_acc;
   logic [7:0]           r_cnt, r_tiles;
   logic [4:0]           r_shift;
   logic                 r_relu, r_ovf;
   logic signed [OW-1:0] r_out;
   logic                 w_xfer, w_last, w_acc_ovf, w_hi, w_lo;
   logic [7:0]           w_tiles_eff;
   logic signed [AW-1:0] w_base, w_acc_nx;
   logic signed [AW:0]   w_ext, w_sum, w_half, w_rnd, w_q, w_r;
   logic signed [OW-1:0] w_qout;
   assign o_in_ready  = rst_n && (r_state == IDLE || r_state == ACC);
   assign w_xfer      = i_in_valid && o_in_ready;
   assign w_tiles_eff = (i_cfg_tiles == 8'd0) ? 8'd1 : i_cfg_tiles;
   // in IDLE the group length comes from the live pins, afterwards from the shadow copy
   assign w_last      = (r_state == IDLE) ? (w_tiles_eff == 8'd1) : (r_cnt + 8'd1 == r_tiles);
   // accumulate one bit wider so overflow is visible, then clamp to the AW-bit range
   assign w_base      = (r_state == IDLE) ? i_bias : r_acc;
   assign w_ext       = {{(AW + 1 - PW){i_in_psum[PW-1]}}, i_in_psum};
   assign w_sum       = {w_base[AW-1], w_base} + w_ext;
   assign w_acc_ovf   = w_sum[AW] ^ w_sum[AW-1];
   assign w_acc_nx    = w_acc_ovf ? (w_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}})
                                  : w_sum[AW-1:0];
   // round-half-up arithmetic shift at AW+1 bits so the rounding add cannot wrap
   assign w_half      = (r_shift == 5'd0) ? '0 : ((AW + 1)'(1) << (r_shift - 5'd1));
   assign w_rnd       = {r_acc[AW-1], r_acc} + w_half;
   assign w_q         = w_rnd >>> r_shift;
   assign w_r         = (r_relu && w_q[AW]) ? '0 : w_q;
   assign w_hi        = !w_r[AW] && (|w_r[AW-1:OW-1]);
   assign w_lo        = w_r[AW] && !(&w_r[AW-1:OW-1]);
   assign w_qout      = w_hi ? {1'b0, {(OW-1){1'b1}}} : w_lo ? {1'b1, {(OW-1){1'b0}}} : w_r[OW-1:0];
   assign o_out_valid = (r_state == OUT);
   assign o_busy      = (r_state != IDLE);
   assign o_out_data  = r_out;
   assign o_ovf       = r_ovf;
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end
   // next-state logic: accept psums until the group's last one, one QUANT cycle, then hold result
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE, ACC: if (w_xfer) w_next = w_last ? QUANT : ACC;
         QUANT:     w_next = OUT;
         OUT:       if (i_out_ready) w_next = IDLE;
      endcase
   end
   // accumulator, group counter, shadow config, result register and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_tiles <= 8'd1;
         r_shift <= '0;
         r_relu  <= 1'b0;
         r_out   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_acc <= w_acc_nx;
            r_cnt <= (r_state == IDLE) ? 8'd1 : r_cnt + 8'd1;
         end
         if (w_xfer && r_state == IDLE) begin
            r_tiles <= w_tiles_eff;
            r_shift <= i_cfg_shift;
            r_relu  <= i_cfg_relu;
         end
         if (r_state == QUANT) r_out <= w_qout;
         r_ovf <= (w_xfer && w_acc_ovf) || (r_state == QUANT && (w_hi || w_lo)) || (r_ovf && !i_ovf_clr);
      end
   end
endmodule

// File: tb/tb_psum_requant.sv
// tb_psum_requant: directed and random groups checked against an arithmetic reference model
module tb_psum_requant;
   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [7:0]         i_cfg_tiles = '0;
   logic [4:0]         i_cfg_shift = '0;
   logic               i_cfg_relu = 1'b0;
   logic signed [23:0] i_bias = '0;
   logic               i_in_valid = 1'b0;
   logic               o_in_ready;
   logic signed [16:0] i_in_psum = '0;
   logic               o_out_valid;
   logic               i_out_ready = 1'b1;
   logic signed [7:0]  o_out_data;
   logic               o_busy;
   logic               o_ovf;
   logic               i_ovf_clr = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   int pbuf [300];
   bit exp_ovf = 1'b0;
   localparam longint MAXA = 64'sd8388607;
   localparam longint MINA = -64'sd8388608;
   psum_requant dut (
      .clk(clk), .rst_n(rst_n),
      .i_cfg_tiles(i_cfg_tiles), .i_cfg_shift(i_cfg_shift), .i_cfg_relu(i_cfg_relu),
      .i_bias(i_bias),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_psum(i_in_psum),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
      .o_busy(o_busy), .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input longint obs, input longint expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask
   function automatic void model(input int n, input int shift, input int relu, input int bias,
                                 output int res, output bit ov);
      longint acc = longint'(bias);
      longint r;
      ov = 1'b0;
      for (int i = 0; i < n; i++) begin
         acc += longint'(pbuf[i]);
         if (acc > MAXA) begin acc = MAXA; ov = 1'b1; end
         if (acc < MINA) begin acc = MINA; ov = 1'b1; end
      end
      r = acc + ((shift != 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0);
      r = r >>> shift;
      if (relu != 0 && r < 0) r = 0;
      if (r > 127) begin r = 127; ov = 1'b1; end
      if (r < -128) begin r = -128; ov = 1'b1; end
      res = int'(r);
   endfunction
   task automatic run_group(input int tiles, input int shift, input int relu, input int bias,
                            input int bubbles, input int stall);
      int n = (tiles == 0) ? 1 : tiles;
      int eo;
      bit eov;
      model(n, shift, relu, bias, eo, eov);
      exp_ovf |= eov;
      i_cfg_tiles = 8'(tiles);
      i_cfg_shift = 5'(shift);
      i_cfg_relu  = 1'(relu);
      i_bias      = 24'(bias);
      i_out_ready = (stall == 0);
      for (int i = 0; i < n; i++) begin
         if (bubbles != 0 && i > 0) begin
            repeat ($urandom_range(0, 2)) begin
               i_in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         chk("in_ready", o_in_ready, 1);
         i_in_valid = 1'b1;
         i_in_psum  = 17'(pbuf[i]);
         @(posedge clk); #1;
         if (i == 0) begin
            i_cfg_tiles = 8'($urandom);
            i_cfg_shift = 5'($urandom);
            i_cfg_relu  = 1'($urandom);
            i_bias      = 24'($urandom);
         end
      end
      i_in_valid = 1'b0;
      chk("quant_valid", o_out_valid, 0);
      chk("quant_busy", o_busy, 1);
      @(posedge clk); #1;
      chk("out_valid", o_out_valid, 1);
      chk("out_data", o_out_data, eo);
      chk("ovf", o_ovf, exp_ovf);
      for (int s = 0; s < stall; s++) begin
         i_in_valid = 1'b1;
         i_in_psum  = 17'($urandom);
         @(posedge clk); #1;
         chk("stall_valid", o_out_valid, 1);
         chk("stall_data", o_out_data, eo);
         chk("stall_ready", o_in_ready, 0);
      end
      i_in_valid  = 1'b0;
      i_out_ready = 1'b1;
      @(posedge clk); #1;
      chk("done_valid", o_out_valid, 0);
      chk("done_busy", o_busy, 0);
   endtask
   task automatic clear_ovf();
      i_ovf_clr = 1'b1;
      @(posedge clk); #1;
      i_ovf_clr = 1'b0;
      exp_ovf = 1'b0;
      chk("ovf_clr", o_ovf, 0);
   endtask
   initial begin
      #2;
      chk("rst_in_ready", o_in_ready, 0);
      chk("rst_out_valid", o_out_valid, 0);
      chk("rst_out_data", o_out_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ovf", o_ovf, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("idle_in_ready", o_in_ready, 1);
      pbuf[0] = 100;
      run_group(1, 0, 0, 0, 0, 0);
      pbuf[0] = 20; pbuf[1] = -5; pbuf[2] = 7; pbuf[3] = 3;
      run_group(4, 2, 0, 10, 0, 0);
      run_group(4, 2, 0, 10, 1, 0);
      pbuf[0] = -300; pbuf[1] = 50;
      run_group(2, 1, 1, 0, 0, 0);
      run_group(2, 1, 0, 0, 0, 0);
      pbuf[0] = 65535;
      run_group(1, 0, 0, 0, 0, 0);
      clear_ovf();
      for (int i = 0; i < 255; i++) pbuf[i] = 65535;
      run_group(255, 0, 0, 8388000, 0, 0);
      clear_ovf();
      pbuf[0] = 1000; pbuf[1] = -24; pbuf[2] = 7;
      run_group(3, 3, 0, -77, 0, 5);
      i_cfg_tiles = 8'd4; i_cfg_shift = 5'd0; i_cfg_relu = 1'b0; i_bias = 24'd500;
      for (int i = 0; i < 2; i++) begin
         i_in_valid = 1'b1;
         i_in_psum  = 17'sd1234;
         @(posedge clk); #1;
      end
      i_in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      exp_ovf = 1'b0;
      chk("abort_valid", o_out_valid, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_ready", o_in_ready, 0);
      chk("abort_ovf", o_ovf, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      pbuf[0] = 12; pbuf[1] = 34; pbuf[2] = -5; pbuf[3] = 9;
      run_group(4, 0, 0, 3, 0, 0);
      for (int g = 0; g < 30; g++) begin
         if ($urandom_range(0, 1) == 1) clear_ovf();
         for (int i = 0; i < 8; i++) pbuf[i] = int'($urandom_range(0, 131071)) - 65536;
         run_group(int'($urandom_range(0, 8)), int'($urandom_range(0, 23)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 16777215)) - 8388608, int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/psum_requant.md
Name: psum_requant

Overview:
- Downstream stage of the signed 8x8 MAC column. Consumes the (CW+1)-bit partial sums (psums) the column emits.
- Accumulates a configurable number of K-tile psums on top of a bias, then requantizes to int8: rounding arithmetic right shift, optional ReLU, saturation.
- Presents the int8 result on a valid/ready interface to the activation write-back buffer.

Parameters:
- PW, 17, width of the incoming signed psum (MAC CW+1).
- AW, 24, width of the signed internal accumulator and of bias.
- OW, 8, width of the signed output activation.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_tiles  in  8  psums per output group; 0 is treated as 1
- cfg_shift  in  5  right-shift amount, 0..AW-1
- cfg_relu  in  1  1 = clamp negative results to 0
- bias  in  AW  signed bias added once per group
- in_valid  in  1  psum valid
- in_ready  out  1  block can accept a psum
- in_psum  in  PW  signed psum
- out_valid  out  1  int8 result valid
- out_ready  in  1  sink accepts result
- out_data  out  OW  signed requantized result
- busy  out  1  group in progress (state != IDLE)
- ovf  out  1  sticky: accumulator saturation or output saturation occurred
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset values: in_ready=0 during reset, 1 after reset (IDLE). out_valid=0, out_data=0, busy=0, ovf=0. Internal acc=0, cnt=0, state=IDLE.
- A transfer happens when in_valid && in_ready. Likewise, an output transfer happens when out_valid && out_ready.
- FSM states: IDLE, ACC, QUANT, OUT.
- IDLE: in_ready=1. On a transfer:
  - acc <= sat(bias + sext(in_psum)).
  - cfg_tiles, cfg_shift and cfg_relu are latched into shadow registers and used for the whole group.
  - cnt <= 1.
  - Next state is QUANT if the effective tile count is 1, else ACC.
- ACC: in_ready=1. On each transfer: acc <= sat(acc + sext(in_psum)), cnt++. When the transfer is the tiles-th psum, go to QUANT. Bubbles (in_valid=0) hold state.
- QUANT: in_ready=0. One cycle, no handshake.
  - r = (acc + (shift ? 1<<(shift-1) : 0)) >>> shift, computed at AW+1 bits with no wrap.
  - If relu and r<0, r=0.
  - Saturate r to [-128,127]; set ovf if clamped (the ReLU clamp does not count).
  - out_data <= result, out_valid <= 1, go to OUT.
- OUT: in_ready=0. out_valid and out_data are held stable until out_ready. On the transfer, out_valid <= 0 and the FSM goes to IDLE. The next group may be accepted in the cycle after that.
- Latency: the last psum accepted in cycle N gives out_valid=1 in cycle N+2. Back-to-back throughput is tiles+2 cycles per output when out_ready=1.
- Accumulator saturation: if acc+psum exceeds the AW-bit signed range, clamp to the max/min and set ovf. Accumulation continues from the clamped value.
- ovf is sticky. ovf_clr clears it unless a new saturation occurs in the same cycle, in which case set wins.
- Config pins changed mid-group have no effect until the next group.
- Async reset mid-group discards the partial group, drops out_valid immediately and returns to IDLE. Nothing is emitted for the aborted group.
- in_psum is sign-extended from PW to AW bits.

Test Plan:
- tiles=1, bias=0, shift=0, relu=0, psum=100 -> out_data=100, out_valid asserted 2 cycles after the accepted psum, ovf=0.
- tiles=4, bias=10, shift=2, psums 20, -5, 7, 3 -> acc=35, (35+2)>>>2=9 -> out_data=9. Repeat with in_valid bubbles between psums -> same result, in_ready stays 1 in ACC.
- tiles=2, bias=0, shift=1, relu=1, psums -300, 50 -> acc=-250 -> -125 -> ReLU -> out_data=0, ovf=0. Same case with relu=0 -> out_data=-125.
- tiles=1, bias=0, shift=0, psum=65535 (max positive 17-bit) -> out_data=127, ovf=1. Pulse ovf_clr -> ovf=0.
- tiles=255, bias=8388000, psum=65535 repeated -> acc clamps at 8388607, ovf=1, out_data=127.
- Hold out_ready=0 for 5 cycles in OUT -> out_data stable, in_ready=0, in_valid ignored. Assert rst_n=0 mid-ACC -> out_valid=0, busy=0 immediately, and the next group computes correctly from scratch.
